niosfirmware_mem_arbiter: RTL and testbench
===========================================

NIOSFIRMWARE_MEM_ARBITER -- requirements
Module: niosfirmware_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, giving the memory word-address width (2048 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width; byteenable width SHALL be DATA_W/8.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all registers SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have ports a_address / b_address, input, ADDR_W, the requester word address.
REQ-006 The block SHALL have ports a_byteenable / b_byteenable, input, DATA_W/8, the requester byte lanes.
REQ-007 The block SHALL have ports a_read / a_write / b_read / b_write, input, 1 each, the requester commands.
REQ-008 The block SHALL have ports a_writedata / b_writedata, input, DATA_W, the requester write data.
REQ-009 The block SHALL have ports a_waitrequest / b_waitrequest, output, 1 each, to stall the requester.
REQ-010 The block SHALL have ports a_readdata / b_readdata, output, DATA_W, the requester read data.
REQ-011 The block SHALL have ports a_readdatavalid / b_readdatavalid, output, 1 each, to qualify read data.
REQ-012 The block SHALL have memory-side outputs mem_address (ADDR_W), mem_byteenable (DATA_W/8), mem_chipselect (1), mem_write (1), mem_writedata (DATA_W), mem_clken (1), and memory-side input mem_readdata (DATA_W), all connecting to the single-port on-chip RAM.

Function
REQ-013 The block SHALL define a port request as req_x = x_read | x_write; if a port drives read and write together, the block SHALL execute a write and ignore the read.
REQ-014 Grant SHALL be combinational, with at most one grant per cycle: a sole requester SHALL win; when both ports request, the port not equal to register last_grant SHALL win.
REQ-015 last_grant SHALL update to the granted port on every cycle with a grant, and SHALL hold otherwise.
REQ-016 x_waitrequest SHALL equal req_x & ~grant_x; an accepted command is one issued in a cycle where req_x=1 and waitrequest=0.
REQ-017 mem_chipselect SHALL be 1 iff a grant exists; mem_address, mem_byteenable, mem_writedata and mem_write SHALL be muxed from the granted port; with no grant they SHALL be 0.
REQ-018 mem_clken SHALL be constantly 1 while reset is low.
REQ-019 On an accepted read, the block SHALL set register pend_valid<=1 and pend_port<=granted port; otherwise it SHALL set pend_valid<=0.
REQ-020 x_readdatavalid SHALL equal pend_valid & (pend_port==x), exactly 1 cycle after acceptance; both x_readdata outputs SHALL carry mem_readdata unqualified.
REQ-021 Back-to-back reads SHALL sustain one read per cycle with no bubble; a write accepted in the cycle in which readdatavalid is asserted for an earlier read SHALL not disturb that readdatavalid.
REQ-022 Under continuous contention, grants SHALL strictly alternate A,B,A,B; no port SHALL wait more than 1 cycle.
REQ-023 A write SHALL complete in its accept cycle and SHALL produce no response.

Reset
REQ-024 While reset=1, the block SHALL inhibit all grants: x_waitrequest = req_x, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-025 Reset SHALL force last_grant=B, so A wins the first tie, and pend_valid=0.
REQ-026 A read accepted in the cycle before reset asserts SHALL be discarded; no readdatavalid SHALL appear for it after reset.

Verification
REQ-027 Scenario: A writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then reads 0x005 -> A readdatavalid 1 cycle after read accept, with a_readdata=0xDEADBEEF.
REQ-028 Scenario: both ports hold a read for 6 cycles after reset -> grants A,B,A,B,A,B; each readdatavalid pulses on the following cycle to the matching port only.
REQ-029 Scenario: B writes 0x11223344 to address 0x7FF with byteenable 0x3 over prior 0x00000000 -> a subsequent read of 0x7FF returns 0x00003344.
REQ-030 Scenario: A issues read and write together to address 0x010 with data 0xA5A5A5A5 -> mem_write=1, no readdatavalid is produced, and a later read returns 0xA5A5A5A5.
REQ-031 Scenario: A read is accepted, then reset pulses for 1 cycle -> no a_readdatavalid is produced; the first post-reset tie is won by A.

Source files
------------

// File: rtl/niosfirmware_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip RAM.
// The RAM has one cycle of read latency, so each granted read returns on the cycle after it is accepted.
module niosfirmware_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  port_t last_grant;
  port_t pend_port;
  logic  pend_valid;
  logic  req_a, req_b;
  logic  grant_a, grant_b;
  logic  rd_accept;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  // A tie goes to whichever port did not win last; reset blocks every grant.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (req_a && (!req_b || last_grant == PORT_B))
        grant_a = 1'b1;
      else if (req_b)
        grant_b = 1'b1;
    end
  end

  assign a_waitrequest = req_a & ~grant_a;
  assign b_waitrequest = req_b & ~grant_b;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (grant_a) begin
      mem_address    = a_address;
      mem_byteenable = a_byteenable;
      mem_writedata  = a_writedata;
      mem_write      = a_write;
    end else if (grant_b) begin
      mem_address    = b_address;
      mem_byteenable = b_byteenable;
      mem_writedata  = b_writedata;
      mem_write      = b_write;
    end
  end

  assign mem_chipselect = grant_a | grant_b;
  assign mem_clken      = ~reset;

  // A read issued together with a write is treated as a write only.
  assign rd_accept = (grant_a & a_read & ~a_write) | (grant_b & b_read & ~b_write);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_B;
      pend_valid <= 1'b0;
      pend_port  <= PORT_A;
    end else begin
      if (grant_a)
        last_grant <= PORT_A;
      else if (grant_b)
        last_grant <= PORT_B;
      pend_valid <= rd_accept;
      if (rd_accept)
        pend_port <= grant_b ? PORT_B : PORT_A;
    end
  end

  assign a_readdatavalid = pend_valid & (pend_port == PORT_A);
  assign b_readdatavalid = pend_valid & (pend_port == PORT_B);
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;

endmodule

// File: tb/tb_niosfirmware_mem_arbiter.sv
// Directed bench for niosfirmware_mem_arbiter with a behavioural single-port RAM (1-cycle read latency).
module tb_niosfirmware_mem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] a_address, b_address;
  logic [BE_W-1:0]   a_byteenable, b_byteenable;
  logic              a_read, a_write, b_read, b_write;
  logic [DATA_W-1:0] a_writedata, b_writedata;
  logic              a_waitrequest, b_waitrequest;
  logic [DATA_W-1:0] a_readdata, b_readdata;
  logic              a_readdatavalid, b_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  niosfirmware_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read data, byte-lane writes.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int i = 0; i < BE_W; i++)
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic set_idle();
    a_read = 0; a_write = 0; a_address = '0; a_byteenable = '0; a_writedata = '0;
    b_read = 0; b_write = 0; b_address = '0; b_byteenable = '0; b_writedata = '0;
  endtask

  task automatic drive_a(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [BE_W-1:0] be, input logic [DATA_W-1:0] data);
    a_read = rd; a_write = wr; a_address = addr; a_byteenable = be; a_writedata = data;
  endtask

  task automatic drive_b(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [BE_W-1:0] be, input logic [DATA_W-1:0] data);
    b_read = rd; b_write = wr; b_address = addr; b_byteenable = be; b_writedata = data;
  endtask

  task automatic pulse_reset();
    @(negedge clk); set_idle(); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    set_idle();
    drive_a(1, 0, 11'h001, 4'hF, '0);
    drive_b(0, 1, 11'h002, 4'hF, 32'h1);
    @(negedge clk); #1;
    checks++; if (a_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL reset_a_wait got=%b exp=1", a_waitrequest); end
    checks++; if (b_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL reset_b_wait got=%b exp=1", b_waitrequest); end
    checks++; if (mem_chipselect !== 1'b0) begin failures++; $display("[TB] FAIL reset_cs got=%b exp=0", mem_chipselect); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_write got=%b exp=0", mem_write); end
    checks++; if (mem_clken !== 1'b0) begin failures++; $display("[TB] FAIL reset_clken got=%b exp=0", mem_clken); end
    checks++; if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdv got=%b%b exp=00", a_readdatavalid, b_readdatavalid); end
    @(negedge clk); set_idle(); reset = 0; #1;
    checks++; if (mem_clken !== 1'b1) begin failures++; $display("[TB] FAIL run_clken got=%b exp=1", mem_clken); end
  endtask

  task automatic test_write_read();
    @(negedge clk); drive_a(0, 1, 11'h005, 4'hF, 32'hDEADBEEF); #1;
    checks++; if (a_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b1) begin failures++; $display("[TB] FAIL wr_accept got=wait%b cs%b wr%b exp=wait0 cs1 wr1", a_waitrequest, mem_chipselect, mem_write); end
    checks++; if (mem_address !== 11'h005 || mem_writedata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wr_mux got=%h/%h exp=005/deadbeef", mem_address, mem_writedata); end
    @(negedge clk); drive_a(1, 0, 11'h005, 4'hF, '0); #1;
    checks++; if (a_waitrequest !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("[TB] FAIL rd_accept got=wait%b wr%b exp=wait0 wr0", a_waitrequest, mem_write); end
    checks++; if (a_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL wr_no_resp got=%b exp=0", a_readdatavalid); end
    @(negedge clk); set_idle(); #1;
    checks++; if (a_readdatavalid !== 1'b1 || b_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL rd_valid got=a%b b%b exp=a1 b0", a_readdatavalid, b_readdatavalid); end
    checks++; if (a_readdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_data got=%h exp=deadbeef", a_readdata); end
    @(negedge clk); #1;
    checks++; if (a_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL rd_valid_single got=%b exp=0", a_readdatavalid); end
  endtask

  task automatic test_partial_write();
    @(negedge clk); drive_b(0, 1, 11'h7FF, 4'h3, 32'h11223344); #1;
    checks++; if (b_waitrequest !== 1'b0 || mem_byteenable !== 4'h3 || mem_address !== 11'h7FF) begin failures++; $display("[TB] FAIL pw_mux got=wait%b be%h addr%h exp=wait0 be3 addr7ff", b_waitrequest, mem_byteenable, mem_address); end
    @(negedge clk); drive_b(1, 0, 11'h7FF, 4'hF, '0); #1;
    checks++; if (b_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL pw_rd_accept got=%b exp=0", b_waitrequest); end
    @(negedge clk); set_idle(); #1;
    checks++; if (b_readdatavalid !== 1'b1 || a_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL pw_valid got=a%b b%b exp=a0 b1", a_readdatavalid, b_readdatavalid); end
    checks++; if (b_readdata !== 32'h00003344) begin failures++; $display("[TB] FAIL pw_data got=%h exp=00003344", b_readdata); end
  endtask

  task automatic test_contention();
    logic exp_ga;
    logic prev_a;
    logic [DATA_W-1:0] exp_data;
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 6) begin
        drive_a(1, 0, 11'h005, 4'hF, '0);
        drive_b(1, 0, 11'h7FF, 4'hF, '0);
      end else set_idle();
      #1;
      exp_ga = (i % 2 == 0);
      prev_a = ((i - 1) % 2 == 0);
      exp_data = prev_a ? 32'hDEADBEEF : 32'h00003344;
      if (i < 6) begin
        checks++; if (a_waitrequest !== !exp_ga || b_waitrequest !== exp_ga) begin failures++; $display("[TB] FAIL cont_grant cyc=%0d got=waitA%b waitB%b exp=waitA%b waitB%b", i, a_waitrequest, b_waitrequest, !exp_ga, exp_ga); end
      end
      if (i == 0) begin
        checks++; if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL cont_rdv0 got=a%b b%b exp=a0 b0", a_readdatavalid, b_readdatavalid); end
      end else begin
        checks++; if (a_readdatavalid !== prev_a || b_readdatavalid !== !prev_a) begin failures++; $display("[TB] FAIL cont_rdv cyc=%0d got=a%b b%b exp=a%b b%b", i, a_readdatavalid, b_readdatavalid, prev_a, !prev_a); end
        checks++; if (a_readdata !== exp_data) begin failures++; $display("[TB] FAIL cont_data cyc=%0d got=%h exp=%h", i, a_readdata, exp_data); end
      end
    end
  endtask

  task automatic test_read_write_same();
    @(negedge clk); set_idle(); drive_a(1, 1, 11'h010, 4'hF, 32'hA5A5A5A5); #1;
    checks++; if (mem_write !== 1'b1 || a_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL rw_write got=wr%b wait%b exp=wr1 wait0", mem_write, a_waitrequest); end
    @(negedge clk); set_idle(); #1;
    checks++; if (a_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL rw_no_resp got=%b exp=0", a_readdatavalid); end
    @(negedge clk); drive_a(1, 0, 11'h010, 4'hF, '0);
    @(negedge clk); set_idle(); #1;
    checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL rw_readback got=v%b %h exp=v1 a5a5a5a5", a_readdatavalid, a_readdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_idle(); drive_a(1, 0, 11'h005, 4'hF, '0);
    @(negedge clk); drive_a(1, 0, 11'h7FF, 4'hF, '0); #1;
    checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'hDEADBEEF || a_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first got=v%b %h wait%b exp=v1 deadbeef wait0", a_readdatavalid, a_readdata, a_waitrequest); end
    @(negedge clk); set_idle(); drive_b(0, 1, 11'h020, 4'hF, 32'hCAFEF00D); #1;
    checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'h00003344) begin failures++; $display("[TB] FAIL b2b_second got=v%b %h exp=v1 00003344", a_readdatavalid, a_readdata); end
    checks++; if (b_waitrequest !== 1'b0 || mem_write !== 1'b1 || b_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_write got=wait%b wr%b bv%b exp=wait0 wr1 bv0", b_waitrequest, mem_write, b_readdatavalid); end
    @(negedge clk); set_idle(); #1;
    checks++; if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_after_write got=a%b b%b exp=a0 b0", a_readdatavalid, b_readdatavalid); end
  endtask

  task automatic test_reset_discard();
    @(negedge clk); set_idle(); drive_a(1, 0, 11'h005, 4'hF, '0); #1;
    checks++; if (a_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL disc_accept got=%b exp=0", a_waitrequest); end
    @(posedge clk); #1; set_idle(); reset = 1;
    @(negedge clk); #1;
    checks++; if (a_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL disc_rdv_in_reset got=%b exp=0", a_readdatavalid); end
    @(posedge clk); #1; reset = 0;
    @(negedge clk); #1;
    checks++; if (a_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL disc_rdv_after got=%b exp=0", a_readdatavalid); end
    drive_a(1, 0, 11'h005, 4'hF, '0); drive_b(1, 0, 11'h7FF, 4'hF, '0); #1;
    checks++; if (a_waitrequest !== 1'b0 || b_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL disc_first_tie got=waitA%b waitB%b exp=waitA0 waitB1", a_waitrequest, b_waitrequest); end
    @(negedge clk); set_idle(); #1;
    checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL disc_tie_read got=v%b %h exp=v1 deadbeef", a_readdatavalid, a_readdata); end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_contention();
    test_read_write_same();
    test_back_to_back();
    test_reset_discard();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
